// File: rtl/line_burst_adapter_if.sv
// CPU-side word port and physical-memory burst port of line_burst_adapter.
// master = CPU + memory environment, slave = the adapter.
interface line_burst_adapter_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;

  modport slave (
    input  mem_read, mem_write, mem_address,
    input  mem_wdata, mem_byte_enable,
    output mem_rdata, mem_resp,
    output pmem_read, pmem_write,
    output pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output mem_read, mem_write, mem_address,
    output mem_wdata, mem_byte_enable,
    input  mem_rdata, mem_resp,
    input  pmem_read, pmem_write,
    input  pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/line_burst_adapter.sv
// Single-line buffer between a 32-bit CPU port and a 4x64 burst memory.
// Macro LINE_BUFFER_HIT_EN enables hits on the buffered line.
module line_burst_adapter (
  input logic                clk,
  input logic                rst,
  line_burst_adapter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] WB   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [255:0] data_q, data_d;
  logic [26:0]  tag_q, tag_d;
  logic         valid_q, valid_d;
  logic [1:0]   k_q, k_d;
  logic [26:0]  rtag_q, rtag_d;
  logic [2:0]   word_q, word_d;
  logic         wr_q, wr_d;
  logic [31:0]  wdata_q, wdata_d;
  logic [3:0]   be_q, be_d;
  logic [31:0]  rdata_q, rdata_d;
  logic [31:0]  paddr_q, paddr_d;
  logic         hit;
  logic [31:0]  cur_word;

  function automatic logic [255:0] merge(
    input logic [255:0] l,
    input logic [2:0]   w,
    input logic [31:0]  d,
    input logic [3:0]   be
  );
    logic [255:0] r;
    r = l;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[int'(w)*32 + i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

`ifdef LINE_BUFFER_HIT_EN
  assign hit = valid_q &&
               (tag_q == bus.mem_address[31:5]);
  logic unused_ok;
  assign unused_ok = ^bus.mem_address[1:0];
`else
  // Buffer state is still kept so the build differs only in hit.
  assign hit = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{bus.mem_address[1:0], tag_q, valid_q};
`endif

  assign cur_word = data_q[int'(word_q)*32 +: 32];

  assign bus.mem_resp     = (state_q == RESP);
  assign bus.mem_rdata    = (state_q == RESP && !wr_q) ?
                            cur_word : rdata_q;
  assign bus.pmem_read    = (state_q == FILL);
  assign bus.pmem_write   = (state_q == WB);
  assign bus.pmem_address = paddr_q;
  assign bus.pmem_wdata   = (state_q == WB) ?
                            data_q[int'(k_q)*64 +: 64] : 64'd0;

  // Next-state: request capture, burst beats, merge, response.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    k_d     = k_q;
    rtag_d  = rtag_q;
    word_d  = word_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    paddr_d = paddr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          rtag_d  = bus.mem_address[31:5];
          word_d  = bus.mem_address[4:2];
          wr_d    = bus.mem_write;
          wdata_d = bus.mem_wdata;
          be_d    = bus.mem_byte_enable;
          k_d     = 2'd0;
          paddr_d = {bus.mem_address[31:5], 5'b0};
          if (hit) begin
            if (bus.mem_write) begin
              data_d = merge(data_q, bus.mem_address[4:2],
                             bus.mem_wdata,
                             bus.mem_byte_enable);
              state_d = WB;
            end else begin
              state_d = RESP;
            end
          end else begin
            valid_d = 1'b0;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (bus.pmem_resp) begin
          data_d[int'(k_q)*64 +: 64] = bus.pmem_rdata;
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) begin
            tag_d   = rtag_q;
            valid_d = 1'b1;
            if (wr_q) begin
              data_d  = merge(data_d, word_q, wdata_q, be_q);
              state_d = WB;
            end else begin
              state_d = RESP;
            end
          end
        end
      end
      WB: begin
        if (bus.pmem_resp) begin
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) state_d = RESP;
        end
      end
      RESP: begin
        if (!wr_q) rdata_d = cur_word;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any burst and drops the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
      k_q     <= 2'd0;
      rtag_q  <= '0;
      word_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      paddr_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
      k_q     <= k_d;
      rtag_q  <= rtag_d;
      word_q  <= word_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      paddr_q <= paddr_d;
    end
  end

endmodule

// File: tb/tb_line_burst_adapter.sv
// Directed bench for line_burst_adapter with a line-level model.
// Works with LINE_BUFFER_HIT_EN defined or undefined.
module tb_line_burst_adapter;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  line_burst_adapter_if bus ();

  line_burst_adapter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [255:0] pm [logic [31:0]];
  logic         m_valid = 1'b0;
  logic [26:0]  m_tag = '0;
  logic [255:0] m_line = '0;
  logic [31:0]  exp_hold = '0;
  logic [31:0]  exp_paddr = '0;
  bit           chk_en = 1'b0;
  logic [63:0]  wb_cap [4];
  logic [31:0]  got;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] pm_get(input logic [31:0] la);
    logic [255:0] r;
    if (pm.exists(la)) return pm[la];
    for (int j = 0; j < 4; j++)
      r[64*j +: 64] = {la ^ 32'hA5A5_0000,
                       32'h0BEA_0000 + 32'(j)};
    return r;
  endfunction

  function automatic logic [255:0] merge_m(
    input logic [255:0] l, input logic [2:0] w,
    input logic [31:0] d, input logic [3:0] be);
    logic [255:0] r;
    r = l;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*(4*int'(w) + b) +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Every-cycle invariants against the model.
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      check("excl", {63'd0, bus.pmem_read && bus.pmem_write}, 64'd0);
      if (bus.pmem_read || bus.pmem_write)
        check("paddr", {32'd0, bus.pmem_address}, {32'd0, exp_paddr});
      if (!bus.mem_resp)
        check("hold", {32'd0, bus.mem_rdata}, {32'd0, exp_hold});
    end
  end

  task automatic access(input bit rd, input bit wr,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [3:0] be,
                        input bit stall,
                        input string nm,
                        output logic [31:0] rg);
    logic [31:0]  la;
    logic [31:0]  ew;
    logic [255:0] src;
    logic [255:0] ld;
    bit hit;
    bit fill;
    int cyc, rb, wn, nresp, lat;
    la = {a[31:5], 5'b0};
`ifdef LINE_BUFFER_HIT_EN
    hit = m_valid && (m_tag == a[31:5]);
`else
    hit = 1'b0;
`endif
    fill = !hit;
    src = pm_get(la);
    ld = fill ? src : m_line;
    if (wr) ld = merge_m(ld, a[4:2], wd, be);
    ew = ld[32*int'(a[4:2]) +: 32];
    exp_paddr = la;
    bus.mem_read = rd;
    bus.mem_write = wr;
    bus.mem_address = a;
    bus.mem_wdata = wd;
    bus.mem_byte_enable = be;
    cyc = 0; rb = 0; wn = 0; nresp = 0; lat = 0; rg = '0;
    while (nresp == 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      bus.pmem_resp = 1'b0;
      if (bus.mem_resp) begin
        nresp++;
        lat = cyc;
        rg = bus.mem_rdata;
        if (rd && !wr) exp_hold = ew;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
      end else if (bus.pmem_read && (!stall || cyc % 2 == 0)) begin
        bus.pmem_rdata = (rb < 4) ? src[64*rb +: 64] : 64'd0;
        rb++;
        bus.pmem_resp = 1'b1;
      end else if (bus.pmem_write && (!stall || cyc % 2 == 0)) begin
        if (wn < 4) wb_cap[wn] = bus.pmem_wdata;
        wn++;
        bus.pmem_resp = 1'b1;
      end
    end
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.mem_resp) nresp++;
    end
    check({nm, " resp"}, 64'(nresp), 64'd1);
    check({nm, " rbeats"}, 64'(rb), fill ? 64'd4 : 64'd0);
    check({nm, " wbeats"}, 64'(wn), wr ? 64'd4 : 64'd0);
    if (wr && wn == 4)
      for (int j = 0; j < 4; j++)
        check({nm, " wbdata"}, wb_cap[j], ld[64*j +: 64]);
    if (!stall)
      check({nm, " lat"}, 64'(lat),
            64'(1 + (fill ? 4 : 0) + (wr ? 4 : 0)));
    if (rd && !wr)
      check({nm, " rdata"}, {32'd0, rg}, {32'd0, ew});
    else
      check({nm, " wr_rdata"}, {32'd0, rg}, {32'd0, exp_hold});
    m_valid = 1'b1;
    m_tag = a[31:5];
    m_line = ld;
    if (wr) pm[la] = ld;
  endtask

  task automatic abort_fill(input logic [31:0] a);
    logic [31:0]  la;
    logic [255:0] src;
    int given, cyc;
    la = {a[31:5], 5'b0};
    src = pm_get(la);
    exp_paddr = la;
    given = 0; cyc = 0;
    bus.mem_read = 1'b1;
    bus.mem_address = a;
    while (given < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      bus.pmem_resp = 1'b0;
      if (bus.pmem_read) begin
        bus.pmem_rdata = src[64*given +: 64];
        given++;
        bus.pmem_resp = 1'b1;
      end
    end
    check("abort beats", 64'(given), 64'd2);
    @(posedge clk);
    #2;
    check("abort pre_rd", {63'd0, bus.pmem_read}, 64'd1);
    exp_hold = '0;
    rst = 1'b1;
    #1;
    check("abort rd", {63'd0, bus.pmem_read}, 64'd0);
    check("abort resp", {63'd0, bus.mem_resp}, 64'd0);
    check("abort paddr", {32'd0, bus.pmem_address}, 64'd0);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    bus.mem_read = 1'b0;
    rst = 1'b0;
    m_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort noresp", {63'd0, bus.mem_resp}, 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_address = '0;
    bus.mem_wdata = '0;
    bus.mem_byte_enable = '0;
    bus.pmem_rdata = '0;
    bus.pmem_resp = 1'b0;
    pm[32'h0000_1000] = {64'h4444_4444_4444_4444,
                         64'h3333_3333_3333_3333,
                         64'h2222_2222_2222_2222,
                         64'h1111_1111_1111_1111};
    repeat (2) @(negedge clk);
    check("rst mem_resp", {63'd0, bus.mem_resp}, 64'd0);
    check("rst pmem_read", {63'd0, bus.pmem_read}, 64'd0);
    check("rst pmem_write", {63'd0, bus.pmem_write}, 64'd0);
    check("rst paddr", {32'd0, bus.pmem_address}, 64'd0);
    check("rst wdata", bus.pmem_wdata, 64'd0);
    check("rst rdata", {32'd0, bus.mem_rdata}, 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    access(1, 0, 32'h0000_1004, '0, 4'h0, 0, "rd1004", got);
    check("pin 1004", {32'd0, got}, 64'h1111_1111);
    access(1, 0, 32'h0000_1018, '0, 4'h0, 0, "rd1018", got);
    check("pin 1018", {32'd0, got}, 64'h4444_4444);
    access(0, 1, 32'h0000_1008, 32'hAABB_CCDD, 4'b0101, 0,
           "wr1008", got);
    check("pin wb1", wb_cap[1], 64'h2222_2222_22BB_22DD);
    check("pin wb0", wb_cap[0], 64'h1111_1111_1111_1111);
    access(1, 0, 32'h0000_1008, '0, 4'h0, 0, "rd1008", got);
    check("pin 1008", {32'd0, got}, 64'h22BB_22DD);
    access(0, 1, 32'h0000_100C, 32'hFFFF_FFFF, 4'b0000, 0,
           "wr_be0", got);

    @(negedge clk);
    bus.pmem_resp = 1'b1;
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    check("idle resp", {62'd0, bus.pmem_read, bus.mem_resp}, 64'd0);

    access(1, 1, 32'h0000_2000, 32'h1234_5678, 4'b1111, 1,
           "rdwr2000", got);
    check("pin wb2000", {32'd0, wb_cap[0][31:0]}, 64'h1234_5678);
    access(1, 0, 32'h0000_201C, '0, 4'h0, 1, "rd201c", got);

    abort_fill(32'h0000_3000);
    access(1, 0, 32'h0000_3000, '0, 4'h0, 0, "reread3000", got);
    access(1, 0, 32'h0000_301C, '0, 4'h0, 0, "rd301c", got);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/line_burst_adapter.md
LINE_BURST_ADAPTER -- requirements
Module: line_burst_adapter

Interface
REQ-001 The block SHALL have no parameters; line = 256 bits, burst = 4 beats x 64 bits, both fixed.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 mem_read  in  1  CPU read request, held until mem_resp.
REQ-005 mem_write  in  1  CPU write request, held until mem_resp.
REQ-006 mem_address  in  32  CPU word address; bits [1:0] ignored.
REQ-007 mem_wdata  in  32  CPU store data.
REQ-008 mem_byte_enable  in  4  per-byte write mask, bit i = byte i.
REQ-009 mem_rdata  out  32  CPU load data.
REQ-010 mem_resp  out  1  one-cycle completion pulse.
REQ-011 pmem_read  out  1  burst read request to physical memory.
REQ-012 pmem_write  out  1  burst write request to physical memory.
REQ-013 pmem_address  out  32  line address, bits [4:0] always 0.
REQ-014 pmem_wdata  out  64  current write beat.
REQ-015 pmem_rdata  in  64  current read beat.
REQ-016 pmem_resp  in  1  one pulse per beat accepted/returned.

Function
REQ-017 States SHALL be IDLE, FILL, WB, RESP; line buffer = data[255:0], tag[26:0], valid.
REQ-018 IDLE: on mem_read|mem_write, tag = mem_address[31:5], word = mem_address[4:2]; mem_write wins if both are high.
REQ-019 Hit = valid && tag match; read hit -> RESP; write hit -> merge enabled bytes into data word, then WB.
REQ-020 Miss -> FILL with pmem_read=1, pmem_address={tag,5'b0}, beat counter 0.
REQ-021 FILL: each pmem_resp stores pmem_rdata into data[64k+63:64k], k = 0..3 in order; on 4th beat, pmem_read drops, tag loads, valid=1; read -> RESP, write -> merge then WB.
REQ-022 WB: pmem_write=1, pmem_wdata = data[64k+63:64k]; advance k on pmem_resp; after 4th beat pmem_write drops, -> RESP.
REQ-023 RESP: mem_resp=1 for exactly one cycle, mem_rdata = data word[word] (reads), then IDLE.
REQ-024 mem_rdata SHALL hold its value until the next read response.
REQ-025 pmem_read and pmem_write SHALL never be asserted together; pmem_address is stable for a whole burst.
REQ-026 Write with mem_byte_enable=4'b0000 SHALL still perform WB of the unchanged line.
REQ-027 Latency: read hit = mem_resp 1 cycle after request sampled; miss = 4 beats + 1 cycle; write adds 4 WB beats.
REQ-028 No request is accepted in RESP; next request is sampled in IDLE the following cycle.
REQ-029 Beat counter wraps 3 -> 0 at burst end; pmem_resp outside FILL/WB SHALL be ignored.

Reset
REQ-030 rst SHALL immediately force state=IDLE, valid=0, k=0, mem_resp=0, pmem_read=0, pmem_write=0, mem_rdata=0, pmem_address=0, pmem_wdata=0.
REQ-031 rst mid-burst SHALL abandon the burst; no partial line becomes valid and the aborted CPU request gets no mem_resp.

Configuration
REQ-032 Macro LINE_BUFFER_HIT_EN defined: hit path per REQ-019.
REQ-033 LINE_BUFFER_HIT_EN undefined: hit forced to 0; every access performs FILL (and WB for writes); ports unchanged.

Verification
REQ-034 Read 0x0000_1004 after reset -> pmem_read, pmem_address=0x0000_1000, 4 beats 0x11..11/0x22..22/0x33..33/0x44..44 -> mem_rdata=0x1111_1111, one mem_resp.
REQ-035 Then read 0x0000_1018 -> no pmem activity, mem_rdata=0x4444_4444 one cycle after request (macro defined); with macro undefined -> full refill first.
REQ-036 Write 0x0000_1008, wdata=0xAABB_CCDD, byte_enable=4'b0101 -> WB beat1 = 0x2222_2222_22BB_22DD, other beats unchanged, then mem_resp.
REQ-037 Assert mem_read and mem_write together to 0x0000_2000 -> treated as write: FILL then WB, single mem_resp.
REQ-038 rst asserted after beat 2 of a FILL -> pmem_read low same cycle, no mem_resp; re-read same address -> full 4-beat FILL.
